// File: rtl/dca_matrix_mac_pkg.sv
// rtl/dca_matrix_mac_pkg.sv - shared types and saturation helper for the DCA matrix MAC tile engine
package dca_matrix_mac_pkg;

  localparam int K_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [K_MAX-1:0] k;
    logic             is_signed;
    logic             accumulate;
    logic             store;
    logic             saturate;
  } inst_t;

  // v arrives already sign- or zero-extended to 64 bits according to is_signed
  function automatic logic [63:0] sat_clamp(input logic [63:0] v, input logic is_signed,
                                            input int bw_out);
    logic signed [63:0] sv;
    logic signed [63:0] smax;
    logic signed [63:0] smin;
    logic        [63:0] umax;
    sv   = signed'(v);
    smax = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (bw_out - 1));
    umax = (64'd1 << bw_out) - 64'd1;
    if (is_signed) begin
      if (sv > smax) return smax;
      if (sv < smin) return smin;
      return v;
    end
    if (v > umax) return umax;
    return v;
  endfunction

endpackage

// File: rtl/dca_matrix_mac_tile_engine_cell.sv
// rtl/dca_matrix_mac_tile_engine_cell.sv - single accumulator: extend, multiply, add, clear
module dca_mac_cell #(
  parameter int BW_ELEM = 8,
  parameter int BW_ACC  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              signed_i,
  input  logic [BW_ELEM-1:0] a_i,
  input  logic [BW_ELEM-1:0] b_i,
  output logic [BW_ACC-1:0]  acc_o
);

  logic [BW_ACC-1:0]           acc_q;
  logic signed [BW_ELEM:0]     a_ext;
  logic signed [BW_ELEM:0]     b_ext;
  logic signed [2*BW_ELEM+1:0] prod;
  logic signed [BW_ACC-1:0]    prod_acc;

  // one extra bit lets a single signed multiplier serve both modes
  assign a_ext    = {signed_i & a_i[BW_ELEM-1], a_i};
  assign b_ext    = {signed_i & b_i[BW_ELEM-1], b_i};
  assign prod     = a_ext * b_ext;
  assign prod_acc = BW_ACC'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + $unsigned(prod_acc);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dca_matrix_mac_tile_engine.sv
// rtl/dca_matrix_mac_tile_engine.sv - outer-product MAC tile engine: FSM, beat/row counters, output mux
module dca_matrix_mac_tile_engine
  import dca_matrix_mac_pkg::*;
#(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int BW_ELEM = 8,
  parameter int BW_ACC  = 32,
  parameter int BW_OUT  = 16,
  parameter int BW_K    = 16,
  localparam int RW     = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  input  logic [BW_K-1:0]            inst_k,
  input  logic                       inst_signed,
  input  logic                       inst_accumulate,
  input  logic                       inst_store,
  input  logic                       inst_saturate,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [NUM_ROW*BW_ELEM-1:0] a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [NUM_COL*BW_ELEM-1:0] b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_COL*BW_OUT-1:0]  out_data,
  output logic [RW-1:0]              out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  state_t           state_q, state_d;
  inst_t            inst_in;
  logic [K_MAX-1:0] k_q, k_d, cnt_q, cnt_d, cnt_inc;
  logic             sgn_q, sgn_d, store_q, store_d, sat_q, sat_d;
  logic [RW-1:0]    row_q, row_d;
  logic             done_q, done_d;
  logic             clr, mac_en, beat;
  logic [BW_ACC-1:0] acc_w [NUM_ROW][NUM_COL];

  assign inst_in.k          = K_MAX'(inst_k);
  assign inst_in.is_signed  = inst_signed;
  assign inst_in.accumulate = inst_accumulate;
  assign inst_in.store      = inst_store;
  assign inst_in.saturate   = inst_saturate;

  assign beat    = a_valid & b_valid;
  assign cnt_inc = cnt_q + K_MAX'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      sgn_q   <= 1'b0;
      store_q <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sgn_q   <= sgn_d;
      store_q <= store_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sgn_d      = sgn_q;
    store_d    = store_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    done_d     = 1'b0;
    clr        = 1'b0;
    mac_en     = 1'b0;
    inst_ready = 1'b0;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_ready = !rst;
        if (inst_valid && !rst) begin
          k_d     = inst_in.k;
          sgn_d   = inst_in.is_signed;
          store_d = inst_in.store;
          sat_d   = inst_in.saturate;
          cnt_d   = '0;
          row_d   = '0;
          clr     = !inst_in.accumulate;
          if (inst_in.k != '0) begin
            state_d = S_COMPUTE;
          end else if (inst_in.store) begin
            state_d = S_OUTPUT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        // both streams are consumed together so A and B beats never drift apart
        a_ready = beat;
        b_ready = beat;
        if (beat) begin
          mac_en = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == k_q) begin
            if (store_q) begin
              state_d = S_OUTPUT;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        out_last  = (row_q == RW'(NUM_ROW - 1));
        if (out_ready) begin
          if (out_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      dca_mac_cell #(
        .BW_ELEM(BW_ELEM),
        .BW_ACC (BW_ACC)
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (mac_en),
        .signed_i(sgn_q),
        .a_i     (a_data[r*BW_ELEM +: BW_ELEM]),
        .b_i     (b_data[c*BW_ELEM +: BW_ELEM]),
        .acc_o   (acc_w[r][c])
      );
    end
  end

  always_comb begin
    logic [BW_ACC-1:0] acc_sel;
    logic [63:0]       acc64;
    logic [63:0]       sat64;
    out_data = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      acc_sel = acc_w[row_q][c];
      acc64   = sgn_q ? 64'(signed'(acc_sel)) : 64'(acc_sel);
      sat64   = sat_clamp(acc64, sgn_q, BW_OUT);
      out_data[c*BW_OUT +: BW_OUT] = sat_q ? sat64[BW_OUT-1:0] : acc_sel[BW_OUT-1:0];
    end
  end

  assign out_row = row_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_dca_matrix_mac_tile_engine.sv
// tb/tb_dca_matrix_mac_tile_engine.sv - directed self-checking bench for the MAC tile engine
module tb_dca_matrix_mac_tile_engine;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int BE = 8;
  localparam int BA = 32;
  localparam int BO = 8;
  localparam int BK = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inst_valid = 1'b0;
  logic              inst_ready;
  logic [BK-1:0]     inst_k = '0;
  logic              inst_signed = 1'b0;
  logic              inst_accumulate = 1'b0;
  logic              inst_store = 1'b0;
  logic              inst_saturate = 1'b0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [NR*BE-1:0]  a_data = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic [NC*BE-1:0]  b_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NC*BO-1:0]  out_data;
  logic [1:0]        out_row;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dca_matrix_mac_tile_engine #(
    .NUM_ROW(NR), .NUM_COL(NC), .BW_ELEM(BE), .BW_ACC(BA), .BW_OUT(BO), .BW_K(BK)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_k(inst_k),
    .inst_signed(inst_signed), .inst_accumulate(inst_accumulate),
    .inst_store(inst_store), .inst_saturate(inst_saturate),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] row4(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic issue(input int k, input bit sgn, input bit acc, input bit st, input bit sat);
    int n;
    n = 0;
    while (!inst_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    expect_eq("inst_ready_wait", inst_ready, 1'b1);
    inst_k          = BK'(k);
    inst_signed     = sgn;
    inst_accumulate = acc;
    inst_store      = st;
    inst_saturate   = sat;
    inst_valid      = 1'b1;
    @(negedge clk);
    inst_valid      = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    a_data  = a;
    b_data  = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    expect_eq("joint_ready", {a_ready, b_ready}, 2'b11);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic read_rows(input logic [NR-1:0][31:0] exp, input bit stall);
    int n;
    for (int r = 0; r < NR; r++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      expect_eq("out_valid", out_valid, 1'b1);
      if (stall) begin
        for (int s = 0; s < 2; s++) begin
          expect_eq("stall_data", out_data, exp[r]);
          expect_eq("stall_row", out_row, r[1:0]);
          @(negedge clk);
          expect_eq("stall_valid", out_valid, 1'b1);
        end
      end
      expect_eq("out_row", out_row, r[1:0]);
      expect_eq("out_last", out_last, (r == NR - 1));
      expect_eq("out_data", out_data, exp[r]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    expect_eq("done_pulse", done, 1'b1);
    expect_eq("busy_idle", busy, 1'b0);
    expect_eq("ready_idle", inst_ready, 1'b1);
    expect_eq("no_extra_valid", out_valid, 1'b0);
  endtask

  logic [NR-1:0][31:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    expect_eq("rst_inst_ready", inst_ready, 1'b0);
    expect_eq("rst_outs", {a_ready, b_ready, out_valid, out_last, busy, done}, 6'b0);
    expect_eq("rst_out_row", out_row, 2'd0);
    rst = 1'b0;
    #1;
    expect_eq("post_rst_ready", inst_ready, 1'b1);
    @(negedge clk);

    // K=2 signed store, a=[1,2,3,4] b=ones twice
    issue(2, 1, 0, 1, 0);
    expect_eq("busy_compute", busy, 1'b1);
    expect_eq("inst_ready_busy", inst_ready, 1'b0);
    beat(32'h04030201, 32'h01010101);
    expect_eq("no_valid_mid", out_valid, 1'b0);
    beat(32'h04030201, 32'h01010101);
    for (int r = 0; r < NR; r++) e[r] = {4{8'(2 * (r + 1))}};
    read_rows(e, 0);
    @(negedge clk);
    expect_eq("done_one_cycle", done, 1'b0);

    // signed -128*-128 and cross terms, saturate then truncate
    issue(1, 1, 0, 1, 1);
    beat(32'h0000FF80, 32'h00007F80);
    e[0] = row4(8'h7F, 8'h80, 8'h00, 8'h00);
    e[1] = row4(8'h7F, 8'h81, 8'h00, 8'h00);
    e[2] = '0;
    e[3] = '0;
    read_rows(e, 0);
    issue(1, 1, 0, 1, 0);
    beat(32'h0000FF80, 32'h00007F80);
    e[0] = row4(8'h00, 8'h80, 8'h00, 8'h00);
    e[1] = row4(8'h80, 8'h81, 8'h00, 8'h00);
    read_rows(e, 0);

    // 0xFF*0xFF: unsigned truncate, unsigned saturate, signed
    issue(1, 0, 0, 1, 0);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    e = {4{32'h01010101}};
    read_rows(e, 0);
    issue(1, 0, 0, 1, 1);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    e = {4{32'hFFFFFFFF}};
    read_rows(e, 0);
    issue(1, 1, 0, 1, 1);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    e = {4{32'h01010101}};
    read_rows(e, 0);

    // silent K=3 followed by accumulate K=1
    issue(3, 0, 0, 0, 0);
    repeat (3) beat(32'h01010101, 32'h01010101);
    expect_eq("silent_no_valid", out_valid, 1'b0);
    expect_eq("silent_done", done, 1'b1);
    expect_eq("silent_idle", busy, 1'b0);
    issue(1, 0, 1, 1, 0);
    beat(32'h01010101, 32'h01010101);
    e = {4{32'h04040404}};
    read_rows(e, 0);

    // staggered streams and output stalls
    issue(2, 0, 0, 1, 0);
    a_data  = 32'h55555555;
    b_data  = 32'h55555555;
    a_valid = 1'b1;
    #1;
    expect_eq("a_only_ready", {a_ready, b_ready}, 2'b00);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b1;
    #1;
    expect_eq("b_only_ready", {a_ready, b_ready}, 2'b00);
    @(negedge clk);
    b_valid = 1'b0;
    beat(32'h04030201, 32'h04030201);
    beat(32'h04030201, 32'h04030201);
    e[0] = row4(8'h02, 8'h04, 8'h06, 8'h08);
    e[1] = row4(8'h04, 8'h08, 8'h0C, 8'h10);
    e[2] = row4(8'h06, 8'h0C, 8'h12, 8'h18);
    e[3] = row4(8'h08, 8'h10, 8'h18, 8'h20);
    read_rows(e, 1);

    // K=0 with store and without
    issue(0, 0, 0, 1, 0);
    expect_eq("k0_valid_next", out_valid, 1'b1);
    e = '0;
    read_rows(e, 0);
    issue(0, 0, 1, 0, 0);
    expect_eq("k0_silent_done", done, 1'b1);
    expect_eq("k0_silent_valid", out_valid, 1'b0);

    // reset mid-compute; next accumulate instruction must start from zero
    issue(4, 1, 1, 1, 0);
    beat(32'h7F7F7F7F, 32'h7F7F7F7F);
    a_valid = 1'b1;
    b_valid = 1'b1;
    rst     = 1'b1;
    #1;
    expect_eq("midrst_outs", {a_ready, b_ready, out_valid, busy, done, inst_ready}, 6'b0);
    expect_eq("midrst_row", out_row, 2'd0);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    issue(1, 1, 1, 1, 0);
    beat(32'h04030201, 32'h01010101);
    for (int r = 0; r < NR; r++) e[r] = {4{8'(r + 1)}};
    read_rows(e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dca_matrix_mac_tile_engine.md
# dca_matrix_mac_tile_engine

Parametrised outer-product MAC engine for the DCA matrix accelerator. It is the compute core behind the matrix MAC MMIO wrapper and sits between the LSU read streams (A column / B row beats) and the LSU write stream (C rows). It generalises the fixed-size MAC in three ways: configurable tile shape and element widths, signed/unsigned operation, and accumulation across instructions with deferred or saturating write-back.

## Interface
Parameters:
- NUM_ROW, 4, tile rows (A beat elements, C output beats)
- NUM_COL, 4, tile columns (B beat elements, C beat elements)
- BW_ELEM, 8, A/B element width
- BW_ACC, 32, accumulator width, ≥ 2*BW_ELEM
- BW_OUT, 16, C element width, ≤ BW_ACC
- BW_K, 16, reduction-length field width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  instruction accepted when high with inst_valid
- inst_k  in  BW_K  reduction length K (beats)
- inst_signed  in  1  1: two's-complement operands; 0: unsigned
- inst_accumulate  in  1  1: keep accumulators; 0: clear at accept
- inst_store  in  1  1: emit C after compute; 0: return to idle silently
- inst_saturate  in  1  1: clamp to BW_OUT; 0: truncate
- a_valid / a_ready  in/out  1  A beat handshake
- a_data  in  NUM_ROW*BW_ELEM  A column k, element r at [r*BW_ELEM +: BW_ELEM]
- b_valid / b_ready  in/out  1  B beat handshake
- b_data  in  NUM_COL*BW_ELEM  B row k, element c likewise
- out_valid / out_ready  out/in  1  C row handshake
- out_data  out  NUM_COL*BW_OUT  C row, element c at [c*BW_OUT +: BW_OUT]
- out_row  out  clog2(NUM_ROW)  current row index
- out_last  out  1  high with final row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when instruction retires

## Operation
- States IDLE → COMPUTE → OUTPUT → IDLE.
- IDLE: inst_ready=1. On accept: latch mode bits and K; if !inst_accumulate clear all NUM_ROW*NUM_COL accumulators; go COMPUTE, or, if K=0, directly to OUTPUT (store=1) or IDLE with done (store=0).
- COMPUTE: a_ready = b_ready = a_valid & b_valid (joint consume; neither stream consumed alone). Per consumed beat: acc[r][c] += ext(a[r])*ext(b[c]); ext is sign- or zero-extension per latched inst_signed; sum wraps modulo 2^BW_ACC. Beat counter increments; on K-th beat go OUTPUT (store=1) or IDLE with done (store=0).
- OUTPUT: rows 0..NUM_ROW-1 in order; out_data from acc[out_row][*]. Saturate: signed clamp to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1] (unsigned mode: clamp to 2^BW_OUT-1); else low BW_OUT bits. Row advances on out_valid&out_ready; handshake of out_last → IDLE, done.
- Accumulators are never cleared by OUTPUT; only by reset or a non-accumulate accept.

## Timing
- Reset values: inst_ready=0 during reset, 1 after; a_ready=b_ready=0, out_valid=0, out_row=0, out_last=0, busy=0, done=0, accumulators 0, state IDLE.
- Single-cycle MAC: accumulators reflect a beat the cycle after its handshake; one beat per cycle sustained.
- First out_valid one cycle after the K-th beat handshake (or after accept when K=0).
- out_data/out_row stable while out_valid & !out_ready; out_valid held until accepted.
- done asserts in the IDLE-entry cycle; next instruction acceptable that same cycle (inst_ready=1).
- inst_ready=0 in COMPUTE/OUTPUT; instruction fields sampled only at accept.
- Reset mid-operation: immediate return to reset values; partial results discarded.

## Structure
- Shared package dca_matrix_mac_pkg: state encoding, instruction field struct (k, signed, accumulate, store, saturate), saturation function.
- Sub-module dca_mac_cell (one accumulator: extend, multiply, add, clear), instantiated NUM_ROW×NUM_COL in a generate loop; FSM, counters and output mux in the top.

## Test plan
- Reset then K=2, signed, store, a=[1,2,3,4] b=[1,1,1,1] twice → rows C[r][c]=2*(r+1), out_last on row 3, done one cycle after.
- Signed a[0]=-128, b[0]=-128, K=1, saturate, BW_OUT=8 → C[0][0]=127; truncate mode → low 8 bits of 16384 = 0.
- Unsigned a=0xFF,b=0xFF K=1 → 65025 (no sign extension); signed same bits → 1.
- Inst store=0 K=3 then inst accumulate=1 store=1 K=1 (all-ones operands) → every C = 4; no out_valid after first inst.
- out_ready toggled, a_valid/b_valid staggered → no beat consumed unless both valid, out_data stable under stall; K=0 store=1 non-accumulate → all-zero rows.
- rst asserted mid-COMPUTE → outputs at reset values next edge; new instruction gives results unpolluted.
